// File: rtl/clk_switch_seq.sv
// Sequencer for the glitch-free clock switch select: quiesces the consumer, flips
// clk_sel, waits out the settle time, then releases the consumer and reports done/err.
module clk_switch_seq #(
  parameter  int SETTLE_CYCLES  = 16,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int CNT_MAX        = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES,
  localparam int CNT_W          = $clog2(CNT_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic quiesce_req,
  input  logic quiesce_ack,
  output logic clk_sel,
  output logic busy,
  output logic done,
  output logic err,
  output logic err_stage
);

  typedef enum logic [2:0] {IDLE, QUIESCE, SWITCH, SETTLE, RELEASE} state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic             tgt, tgt_d;
  logic             clk_sel_d, qreq_d, done_d, err_d, es_d;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  // Saturating increment: the counter must never wrap back into a terminal match.
  assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tgt         <= 1'b0;
      clk_sel     <= 1'b0;
      quiesce_req <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_stage   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      tgt         <= tgt_d;
      clk_sel     <= clk_sel_d;
      quiesce_req <= qreq_d;
      done        <= done_d;
      err         <= err_d;
      err_stage   <= es_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    tgt_d     = tgt;
    clk_sel_d = clk_sel;
    qreq_d    = quiesce_req;
    done_d    = 1'b0;
    err_d     = 1'b0;
    es_d      = err_stage;
    case (state)
      IDLE: begin
        if (req_valid) begin
          tgt_d = req_sel;
          if (req_sel == clk_sel) begin
            done_d = 1'b1;
          end else begin
            state_d = QUIESCE;
            qreq_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      QUIESCE: begin
        // ack is checked first so it wins over a coincident timeout
        if (quiesce_ack) begin
          state_d = SWITCH;
        end else if (cnt == TO_LAST) begin
          state_d = IDLE;
          qreq_d  = 1'b0;
          err_d   = 1'b1;
          es_d    = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SWITCH: begin
        clk_sel_d = tgt;
        cnt_d     = '0;
        state_d   = SETTLE;
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_d = RELEASE;
          qreq_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE: begin
        if (!quiesce_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt == TO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
          es_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/clk_switch_seq.md
Name: clk_switch_seq

Overview:
- Control-side sequencer that drives the select input of the glitch-free clock switch.
- Accepts clock-source change requests from the PMU/CSR, quiesces the downstream consumer, flips the select, and waits a programmable settle time.
- Releases the consumer and reports done or error.
- Runs on the always-on reference clock, which is never one of the switched sources.

Parameters:
- SETTLE_CYCLES, 16, clk cycles held after a select change. Legal range is at least 1, and the value must cover ≥3 periods of the slowest switch source.
- TIMEOUT_CYCLES, 1024, maximum clk cycles spent waiting on quiesce_ack in either direction. Legal range is at least 1.
- CNT_W, $clog2(max(SETTLE_CYCLES,TIMEOUT_CYCLES)+1), shared counter width. Derived; do not override.

Ports:
- clk  in  1  always-on reference clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  switch request
- req_sel  in  1  target source (0=clk0, 1=clk1)
- req_ready  out  1  high only in IDLE
- quiesce_req  out  1  asks consumer to stop traffic
- quiesce_ack  in  1  consumer idle; synchronous to clk
- clk_sel  out  1  registered select to the clock switch
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, sequence complete
- err  out  1  one-cycle pulse, timeout
- err_stage  out  1  valid with err: 0=quiesce entry, 1=release

Behaviour:
- Reset values: state=IDLE, clk_sel=0, quiesce_req=0, req_ready=1, busy=0, done=0, err=0, err_stage=0, cnt=0.
- Rst mid-sequence forces reset values on the next edge, including clk_sel=0. The switch handles the hand-back safely.
- Handshake: a request is accepted on a cycle with req_valid&&req_ready. req_sel is captured into tgt at acceptance. req_valid is ignored outside IDLE.
- IDLE, when accepted with req_sel==clk_sel:
  - Stay in IDLE, done=1 on the next cycle.
  - No quiesce is issued and clk_sel does not change.
- IDLE, when accepted with req_sel!=clk_sel:
  - Go to QUIESCE; quiesce_req=1 from the next cycle. cnt=0.
- QUIESCE:
  - cnt increments each cycle.
  - quiesce_ack sampled 1 → SWITCH.
  - cnt reaches TIMEOUT_CYCLES-1 with ack=0 → IDLE. On the next cycle: quiesce_req=0, err=1, err_stage=0. clk_sel is unchanged.
  - If ack arrives on the same cycle as the timeout, ack wins.
- SWITCH (1 cycle):
  - clk_sel<=tgt. cnt=0. → SETTLE.
- SETTLE:
  - cnt increments each cycle.
  - After exactly SETTLE_CYCLES cycles in SETTLE → RELEASE.
  - clk_sel stays stable and quiesce_req stays 1.
- RELEASE:
  - quiesce_req=0 from entry. cnt counts from 0.
  - quiesce_ack sampled 0 → IDLE with done=1 on the next cycle.
  - Timeout (TIMEOUT_CYCLES cycles, ack still 1) → IDLE with err=1, err_stage=1. The new clk_sel is kept.
- done and err are mutually exclusive. Each is a one-cycle pulse registered on the IDLE-entry edge.
- quiesce_ack already high on QUIESCE entry is accepted. Latency from acceptance to clk_sel change is then 2 cycles.
- Nominal latency, acceptance to done with ack after A cycles and ack drop after D cycles: 1+A+1+SETTLE_CYCLES+D+1 cycles.
- Counter saturates and never wraps. No arithmetic wider than CNT_W.
- A back-to-back request is accepted on the same cycle done pulses, because req_ready=1 in IDLE.

Test Plan:
- Reset, then req_sel=1 with ack following quiesce_req after 3 cycles and dropping 2 cycles after release:
  - clk_sel 0→1 exactly 5 cycles after acceptance, held for 16 settle cycles.
  - done pulses once; busy=1 throughout.
- req_sel=0 while clk_sel=0 → done pulses on the next cycle; quiesce_req never asserts; clk_sel stays 0.
- quiesce_ack tied 0 → after 1024 cycles in QUIESCE: err=1, err_stage=0, quiesce_req=0, clk_sel unchanged, req_ready=1.
- Ack held 1 after release → err=1, err_stage=1 after 1024 RELEASE cycles; clk_sel keeps the new value.
- Assert rst during SETTLE → next cycle clk_sel=0, quiesce_req=0, busy=0, no done/err pulse.
- SETTLE_CYCLES=1, ack pre-asserted, back-to-back requests 1 then 0:
  - Second request accepted on the done cycle.
  - clk_sel sequence 0→1→0; two done pulses; no err.
